// File: rtl/sdio_cmd_log.sv
// sdio_cmd_log: logs SDIO CMD-line captures into a small record FIFO and streams them out as
// bytes through a pull handshake.
//
// Ports:
//   sd_clk        sole clock, rising edge
//   rst           asynchronous active-low reset
//   sd_en         synchronous enable; low flushes the FIFO (statistics kept)
//   finsh_i       capture-done strobe; a rising edge writes one record
//   cmd_i[5:0]    command index of the capture
//   arg_i[31:0]   argument of the capture
//   clr_i         synchronous flush plus clear of overflow/drop statistics
//   byte_rd_i     reader consumes byte_o this cycle
//   byte_o        current head byte (0 when empty)
//   byte_valid_o  FIFO non-empty
//   count_o       stored records, 0..2**DEPTH_LOG2
//   overflow_o    sticky: a record was dropped since reset/clear
//   drop_cnt_o    dropped-record count, saturating at 255
//
// Record layout {drop_flag, cmd[5:0], arg[31:0]} leaves as 5 bytes:
//   {1'b1, drop_flag, cmd}, arg[31:24], arg[23:16], arg[15:8], arg[7:0]
module sdio_cmd_log #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  sd_clk,
  input  logic                  rst,
  input  logic                  sd_en,
  input  logic                  finsh_i,
  input  logic [7:0]            cmd_i,
  input  logic [32:0]           arg_i,
  input  logic                  clr_i,
  input  logic                  byte_rd_i,
  output logic [7:0]            byte_o,
  output logic                  byte_valid_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o,
  output logic [7:0]            drop_cnt_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  logic [38:0]           mem [Depth];

  logic                  finsh_prev_q, finsh_prev_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [2:0]            idx_q, idx_d;
  logic                  pend_drop_q, pend_drop_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;

  logic                  wr, valid, rd_step, pop, full, accept, drop;
  logic [38:0]           head;
  logic [7:0]            byte_mux;
  logic                  unused_bits;

  assign unused_bits = ^{cmd_i[7:6], arg_i[32]};

  assign wr      = finsh_i & ~finsh_prev_q & sd_en;
  assign valid   = (count_q != '0);
  assign rd_step = byte_rd_i & valid;
  assign pop     = rd_step & (idx_q == 3'd4);
  assign full    = (count_q == CntFull);
  // A final-byte pop in the same cycle frees the slot for the incoming record.
  assign accept  = wr & (~full | pop) & ~clr_i;
  assign drop    = wr & full & ~pop & ~clr_i;

  assign head = mem[rd_ptr_q];

  always_comb begin
    byte_mux = 8'h00;
    case (idx_q)
      3'd0:    byte_mux = {1'b1, head[38:32]};
      3'd1:    byte_mux = head[31:24];
      3'd2:    byte_mux = head[23:16];
      3'd3:    byte_mux = head[15:8];
      3'd4:    byte_mux = head[7:0];
      default: byte_mux = 8'h00;
    endcase
  end

  assign byte_o       = valid ? byte_mux : 8'h00;
  assign byte_valid_o = valid;
  assign count_o      = count_q;
  assign overflow_o   = overflow_q;
  assign drop_cnt_o   = drop_cnt_q;

  always_comb begin
    finsh_prev_d = finsh_i;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    idx_d        = idx_q;
    pend_drop_d  = pend_drop_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;

    if (clr_i || !sd_en) begin
      finsh_prev_d = 1'b0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      idx_d        = 3'd0;
      pend_drop_d  = 1'b0;
      if (clr_i) begin
        overflow_d = 1'b0;
        drop_cnt_d = 8'h00;
      end
    end else begin
      if (rd_step) begin
        idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (accept) begin
        wr_ptr_d    = wr_ptr_q + 1'b1;
        pend_drop_d = 1'b0;
      end
      if (drop) begin
        overflow_d  = 1'b1;
        pend_drop_d = 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
      case ({accept, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge sd_clk or negedge rst) begin
    if (!rst) begin
      finsh_prev_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      idx_q        <= 3'd0;
      pend_drop_q  <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= 8'h00;
    end else begin
      finsh_prev_q <= finsh_prev_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      pend_drop_q  <= pend_drop_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Record storage needs no reset: byte_o is masked while the FIFO is empty.
  always_ff @(posedge sd_clk) begin
    if (accept) begin
      mem[wr_ptr_q] <= {pend_drop_q, cmd_i[5:0], arg_i[31:0]};
    end
  end

endmodule

// File: tb/tb_sdio_cmd_log.sv
// Self-checking bench for sdio_cmd_log: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the record FIFO.
module tb_sdio_cmd_log;

  localparam int DEPTH = 8;

  logic        sd_clk = 1'b0;
  logic        rst;
  logic        sd_en;
  logic        finsh_i;
  logic [7:0]  cmd_i;
  logic [32:0] arg_i;
  logic        clr_i;
  logic        byte_rd_i;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic [3:0]  count_o;
  logic        overflow_o;
  logic [7:0]  drop_cnt_o;

  sdio_cmd_log #(.DEPTH_LOG2(3)) dut (
    .sd_clk       (sd_clk),
    .rst          (rst),
    .sd_en        (sd_en),
    .finsh_i      (finsh_i),
    .cmd_i        (cmd_i),
    .arg_i        (arg_i),
    .clr_i        (clr_i),
    .byte_rd_i    (byte_rd_i),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .count_o      (count_o),
    .overflow_o   (overflow_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 sd_clk = ~sd_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of whole records plus reader byte position.
  logic [38:0] mq[$];
  int          m_idx;
  bit          m_pend, m_prev, m_ovf;
  int          m_drops;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte();
    logic [38:0] r;
    if (mq.size() == 0) return 8'h00;
    r = mq[0];
    case (m_idx)
      0:       return {1'b1, r[38:32]};
      1:       return r[31:24];
      2:       return r[23:16];
      3:       return r[15:8];
      default: return r[7:0];
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_idx = 0; m_pend = 0; m_prev = 0; m_ovf = 0; m_drops = 0;
  endtask

  task automatic check_outputs();
    chk("byte_valid", byte_valid_o, mq.size() != 0);
    chk("byte_o", byte_o, exp_byte());
    chk("count", count_o, mq.size());
    chk("overflow", overflow_o, m_ovf);
    chk("drop_cnt", drop_cnt_o, m_drops);
  endtask

  // Apply current inputs for one clock: advance the model, then check after the edge.
  task automatic tick();
    bit rise, pop, full;
    if (clr_i) begin
      model_reset();
    end else if (!sd_en) begin
      mq.delete();
      m_idx = 0; m_pend = 0; m_prev = 0;
    end else begin
      rise   = finsh_i && !m_prev;
      m_prev = finsh_i;
      full   = (mq.size() == DEPTH);
      pop    = byte_rd_i && mq.size() != 0 && m_idx == 4;
      if (byte_rd_i && mq.size() != 0) m_idx = (m_idx == 4) ? 0 : m_idx + 1;
      if (pop) void'(mq.pop_front());
      if (rise) begin
        if (full && !pop) begin
          if (m_drops < 255) m_drops++;
          m_ovf  = 1;
          m_pend = 1;
        end else begin
          mq.push_back({m_pend, cmd_i[5:0], arg_i[31:0]});
          m_pend = 0;
        end
      end
    end
    @(posedge sd_clk);
    @(negedge sd_clk);
    check_outputs();
  endtask

  task automatic cap(input logic [7:0] c, input logic [32:0] a);
    cmd_i = c; arg_i = a; finsh_i = 1'b1;
    tick();
    finsh_i = 1'b0;
    tick();
  endtask

  task automatic drain(input int n);
    byte_rd_i = 1'b1;
    for (int i = 0; i < n; i++) tick();
    byte_rd_i = 1'b0;
  endtask

  logic [7:0] exp_b [5];

  initial begin
    rst = 1'b0; sd_en = 1'b1; finsh_i = 1'b0; cmd_i = '0; arg_i = '0;
    clr_i = 1'b0; byte_rd_i = 1'b0;
    model_reset();
    #3;
    chk("rst_valid", byte_valid_o, 1'b0);
    chk("rst_byte", byte_o, 8'h00);
    chk("rst_count", count_o, 4'd0);
    chk("rst_ovf", overflow_o, 1'b0);
    chk("rst_drops", drop_cnt_o, 8'd0);
    repeat (2) @(negedge sd_clk);
    rst = 1'b1;
    tick();

    // Single capture and drain with fixed expected bytes.
    exp_b = '{8'h91, 8'h12, 8'h34, 8'h56, 8'h78};
    cap(8'h11, 33'h0_1234_5678);
    chk("single_count", count_o, 4'd1);
    for (int i = 0; i < 5; i++) begin
      chk("single_byte", byte_o, exp_b[i]);
      byte_rd_i = 1'b1;
      tick();
    end
    byte_rd_i = 1'b0;
    chk("single_empty_count", count_o, 4'd0);
    chk("single_empty_valid", byte_valid_o, 1'b0);

    // Strobe held high yields one record.
    cmd_i = 8'h07; arg_i = 33'h1_0000_00AA; finsh_i = 1'b1;
    repeat (10) tick();
    finsh_i = 1'b0;
    tick();
    chk("held_count", count_o, 4'd1);
    chk("held_byte0", byte_o, 8'h87);
    drain(5);

    // Overflow: 10 captures into 8 slots.
    for (int i = 0; i < 10; i++) cap(8'(i + 8'h20), {1'b0, 32'($urandom)});
    chk("ovf_count", count_o, 4'd8);
    chk("ovf_drops", drop_cnt_o, 8'd2);
    chk("ovf_flag", overflow_o, 1'b1);
    drain(40);
    cap(8'h03, 33'h0_DEAD_BEEF);
    chk("drop_flag_byte0", byte_o, 8'hC3);
    cap(8'h04, 33'h0_0000_0001);
    drain(5);
    chk("flag_cleared_bits", byte_o[7:6], 2'b10);
    drain(5);

    // Full FIFO with final-byte pop coinciding with a capture.
    for (int i = 0; i < 8; i++) cap(8'(i + 8'h30), {1'b0, 32'($urandom)});
    drain(4);
    byte_rd_i = 1'b1; cmd_i = 8'h2A; arg_i = 33'h0_CAFE_F00D; finsh_i = 1'b1;
    tick();
    byte_rd_i = 1'b0; finsh_i = 1'b0;
    tick();
    chk("simul_drops", drop_cnt_o, 8'd2);
    chk("simul_count", count_o, 4'd8);
    chk("simul_tail_cmd", mq[$][37:32], 6'h2A);
    drain(40);

    // clr_i mid-record.
    cap(8'h15, 33'h0_0102_0304);
    drain(2);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    chk("clr_count", count_o, 4'd0);
    chk("clr_valid", byte_valid_o, 1'b0);
    chk("clr_drops", drop_cnt_o, 8'd0);
    chk("clr_ovf", overflow_o, 1'b0);

    // sd_en low flushes but keeps statistics.
    for (int i = 0; i < 10; i++) cap(8'(i), {1'b1, 32'($urandom)});
    drain(3);
    sd_en = 1'b0;
    tick();
    sd_en = 1'b1;
    chk("en_count", count_o, 4'd0);
    chk("en_drops", drop_cnt_o, 8'd2);
    chk("en_ovf", overflow_o, 1'b1);

    // Asynchronous reset mid-transfer.
    cap(8'h3F, 33'h0_FFFF_FFFF);
    byte_rd_i = 1'b1;
    tick();
    byte_rd_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", byte_valid_o, 1'b0);
    chk("arst_byte", byte_o, 8'h00);
    chk("arst_count", count_o, 4'd0);
    chk("arst_ovf", overflow_o, 1'b0);
    chk("arst_drops", drop_cnt_o, 8'd0);
    @(negedge sd_clk);
    rst = 1'b1;
    model_reset();
    tick();

    // Pointer wrap: 20 captures, at most 3 outstanding, whole-record reads.
    for (int n = 0; n < 20; ) begin
      if (mq.size() < 3 && ($urandom_range(1) == 1 || mq.size() == 0)) begin
        cap(8'($urandom), {1'($urandom_range(1)), 32'($urandom)});
        n++;
      end else begin
        drain(5);
      end
      chk("wrap_le3", count_o <= 4'd3, 1'b1);
    end
    while (mq.size() != 0) drain(5);

    // Random traffic including strobes one low cycle apart, clears and disables.
    for (int i = 0; i < 600; i++) begin
      finsh_i   = ($urandom_range(2) == 0);
      byte_rd_i = ($urandom_range(3) != 0);
      clr_i     = ($urandom_range(80) == 0);
      sd_en     = ($urandom_range(60) != 0);
      cmd_i     = 8'($urandom);
      arg_i     = {1'($urandom_range(1)), 32'($urandom)};
      tick();
    end
    finsh_i = 1'b0; clr_i = 1'b0; sd_en = 1'b1;
    drain(45);
    chk("final_empty", count_o, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdio_cmd_log.md
# sdio_cmd_log

Downstream consumer of the SDIO CMD-line sampler.
- On each completed capture (rising edge of the sampler's finish strobe), stores the 6-bit command index and 32-bit argument as one record in an on-chip FIFO.
- Records are drained as a byte stream through a pull handshake, which the SPI-side readout logic uses to ship captured traffic to the host.
- Tracks records dropped on overflow and marks the first record stored after each drop.

## Interface
- DEPTH_LOG2, 3, FIFO holds 2**DEPTH_LOG2 records
- sd_clk  in  1  sole clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- sd_en  in  1  synchronous enable; low = flush (see Operation)
- finsh_i  in  1  capture-done strobe from sampler
- cmd_i  in  8  captured command; bits [5:0] used
- arg_i  in  33  captured argument; bits [31:0] used, bit 32 ignored
- clr_i  in  1  synchronous clear of FIFO and drop statistics
- byte_rd_i  in  1  reader consumes current byte this cycle
- byte_o  out  8  current head byte
- byte_valid_o  out  1  byte_o valid (FIFO non-empty)
- count_o  out  DEPTH_LOG2+1  stored records
- overflow_o  out  1  sticky: at least one record dropped since reset/clr_i
- drop_cnt_o  out  8  dropped-record count, saturates at 255

## Operation
- Capture detect: registered finsh_prev; write request wr = finsh_i & ~finsh_prev & sd_en. A strobe held high yields exactly one record.
- Record format, 39 bits: {drop_flag, cmd_i[5:0], arg_i[31:0]}.
- drop_flag = 1 on the first record accepted after one or more drops.
- Emitted as 5 bytes, in order:
  - byte0 = {1'b1, drop_flag, cmd[5:0]}; bit7 = 1 marks record start for reader resync.
  - byte1 = arg[31:24], byte2 = arg[23:16], byte3 = arg[15:8], byte4 = arg[7:0].
- FIFO: circular buffer with read/write pointers, DEPTH_LOG2 bits each, wrapping modulo depth. count_o range is 0..2**DEPTH_LOG2.
- Read side: byte index idx (0..4) into the head record.
  - byte_o = mux(head, idx); byte_valid_o = (count_o != 0).
  - byte_rd_i & byte_valid_o: idx increments. When idx==4, idx returns to 0 and the head record is popped.
  - byte_rd_i while !byte_valid_o is ignored.
- Full: wr while count_o == depth and no pop this cycle:
  - record dropped;
  - drop_cnt_o increments, saturating at 255;
  - overflow_o set;
  - internal pend_drop set.
- Next accepted write stores drop_flag = pend_drop, then clears pend_drop.
- Simultaneous wr and final-byte pop when full: the pop frees the slot, the write is accepted, no drop. count_o is unchanged.
- Simultaneous wr and pop when not full: count_o is unchanged, both take effect.
- sd_en low: FIFO flushed (pointers, count, idx, pend_drop to 0) and finsh_prev cleared. overflow_o and drop_cnt_o are kept.
- clr_i high: same flush, plus overflow_o = 0 and drop_cnt_o = 0. clr_i overrides wr in the same cycle.
- A flush mid-record discards the partial record; the reader resyncs on bit7.

## Timing
- Reset (rst low, async) values:
  - byte_valid_o = 0, byte_o = 0, count_o = 0;
  - overflow_o = 0, drop_cnt_o = 0;
  - all pointers, idx, pend_drop and finsh_prev = 0.
- Capture latency: finsh_i rises at edge N → record written at edge N; count_o and byte_valid_o reflect it after edge N (visible in cycle N+1).
- byte_o and byte_valid_o are combinational from registered state only; no input-to-output combinational path except none (byte_rd_i affects outputs only after the next edge).
- Throughput: one byte per cycle with byte_rd_i held high. A record drains in 5 cycles. Back-to-back records have no bubble.
- Pop takes effect at the edge where byte_rd_i is sampled with idx==4. count_o decrements after that edge.
- Sampler strobes arrive no closer than 2 cycles apart; the block still handles strobes separated by one low cycle.

## Test plan
- Single capture: finsh_i pulse with cmd_i=8'h11, arg_i=33'h0_1234_5678, then byte_rd_i held high → bytes 8'h91, 8'h12, 8'h34, 8'h56, 8'h78 on consecutive cycles; count_o goes 1→0 after the fifth read; byte_valid_o drops.
- Strobe held high 10 cycles with cmd 8'h07 → exactly one record; count_o=1.
- Overflow with DEPTH_LOG2=3: 10 captures, no reads → count_o=8, drop_cnt_o=2, overflow_o=1. Drain all 8 records, then capture cmd 8'h03 → its byte0 = 8'hC3. The next capture has byte0 bit6 = 0.
- Full plus simultaneous: FIFO full, reader on byte4 of head asserts byte_rd_i in the same cycle a capture arrives → drop_cnt_o unchanged, count_o stays 8, newest record present at the tail.
- Flushes and reset:
  - clr_i asserted mid-record (idx=2) → count_o=0, byte_valid_o=0, drop_cnt_o=0 next cycle.
  - sd_en low keeps drop_cnt_o.
  - rst pulsed low asynchronously mid-transfer → all outputs 0 immediately.
- Pointer wrap: 20 captures interleaved with full reads (never more than 3 outstanding) → every record emerges in order with correct bytes; count_o never exceeds 3.
